// File: rtl/warp_fetch_arbiter.sv
// Per-warp PC table and rotating-priority multi-grant fetch scheduler for the SM front end.
// Define WFA_PERF_CNT_EN to add the perf_grants / perf_starve counters.
module warp_fetch_arbiter #(
   parameter int NUM_WARPS   = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int ADDR_W      = 32,
   parameter int WID_W       = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_valid,
   input  logic [WID_W-1:0]              start_wid,
   input  logic [ADDR_W-1:0]             start_pc,
   input  logic [NUM_WARPS-1:0]          ib_req,
   input  logic [NUM_WARPS-1:0]          stall,
   input  logic [NUM_WARPS-1:0]          redir_valid,
   input  logic [NUM_WARPS*ADDR_W-1:0]   redir_pc_flat,
   input  logic [NUM_WARPS-1:0]          exit_valid,
   output logic [FETCH_WIDTH-1:0]        fetch_valid,
   output logic [FETCH_WIDTH*WID_W-1:0]  fetch_wid_flat,
   output logic [FETCH_WIDTH*ADDR_W-1:0] fetch_pc_flat,
   output logic [NUM_WARPS-1:0]          kill,
   output logic [NUM_WARPS-1:0]          active,
   output logic                          all_done
`ifdef WFA_PERF_CNT_EN
  ,output logic [31:0]                   perf_grants,
   output logic [31:0]                   perf_starve
`endif
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} wstate_t;

   wstate_t                            st [NUM_WARPS];
   logic [ADDR_W-1:0]                  pc [NUM_WARPS];
   logic [NUM_WARPS-1:0]               run, hit, elig, gnt, ev_exit, kill_nxt, run_nxt;
   logic [WID_W-1:0]                   ptr, ptr_nxt;
   logic                               exit_seen;
   logic [FETCH_WIDTH-1:0]             lane_v;
   logic [FETCH_WIDTH-1:0][WID_W-1:0]  lane_wid;

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      assign run[w]      = (st[w] == RUN);
      assign hit[w]      = start_valid && (start_wid == WID_W'(w));
      assign elig[w]     = run[w] & ib_req[w] & ~stall[w] & ~redir_valid[w] & ~exit_valid[w] & ~hit[w];
      assign ev_exit[w]  = run[w] & exit_valid[w] & ~hit[w];
      // A launch of an IDLE warp has nothing in flight, so only RUN warps are killed.
      assign kill_nxt[w] = run[w] & (redir_valid[w] | exit_valid[w] | hit[w]);
      assign run_nxt[w]  = hit[w] | (run[w] & ~exit_valid[w]);
   end

   assign active = run;

   // Circular scan from ptr; the n-th eligible warp found lands on lane n.
   always_comb begin
      int               n;
      logic [WID_W-1:0] idx;
      gnt      = '0;
      lane_v   = '0;
      lane_wid = '0;
      ptr_nxt  = ptr;
      n        = 0;
      idx      = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx = ptr + WID_W'(i);
         if (elig[idx] && n < FETCH_WIDTH) begin
            for (int l = 0; l < FETCH_WIDTH; l++) begin
               if (n == l) begin
                  lane_v[l]   = 1'b1;
                  lane_wid[l] = idx;
               end
            end
            gnt[idx] = 1'b1;
            ptr_nxt  = idx + WID_W'(1);
            n++;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (!rst_n) begin
            st[w] <= IDLE;
            pc[w] <= '0;
         end else if (hit[w]) begin
            st[w] <= RUN;
            pc[w] <= start_pc;
         end else if (run[w] && exit_valid[w]) begin
            st[w] <= IDLE;
         end else if (run[w] && redir_valid[w]) begin
            pc[w] <= redir_pc_flat[w*ADDR_W +: ADDR_W];
         end else if (gnt[w]) begin
            pc[w] <= pc[w] + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr            <= '0;
         fetch_valid    <= '0;
         fetch_wid_flat <= '0;
         fetch_pc_flat  <= '0;
         kill           <= '0;
         exit_seen      <= 1'b0;
         all_done       <= 1'b0;
      end else begin
         ptr         <= ptr_nxt;
         kill        <= kill_nxt;
         fetch_valid <= lane_v;
         for (int l = 0; l < FETCH_WIDTH; l++) begin
            fetch_wid_flat[l*WID_W +: WID_W]   <= lane_wid[l];
            fetch_pc_flat[l*ADDR_W +: ADDR_W]  <= lane_v[l] ? pc[lane_wid[l]] : '0;
         end
         exit_seen <= exit_seen | (|ev_exit);
         all_done  <= ~start_valid & (exit_seen | (|ev_exit)) & ~(|run_nxt);
      end
   end

`ifdef WFA_PERF_CNT_EN
   logic [31:0] fv_cnt;

   always_comb begin
      fv_cnt = '0;
      for (int l = 0; l < FETCH_WIDTH; l++) fv_cnt = fv_cnt + 32'(fetch_valid[l]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_grants <= '0;
         perf_starve <= '0;
      end else begin
         perf_grants <= perf_grants + fv_cnt;
         if ((|run) && !(|gnt)) perf_starve <= perf_starve + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_warp_fetch_arbiter.sv
// Directed bench for warp_fetch_arbiter: vector table on the 8x2 build plus hand sequences
// for mid-stream reset, pointer reset and the 16x4 PC-wrap configuration.
module tb_warp_fetch_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 8-warp / 2-lane instance
   logic         start_valid = 1'b0;
   logic [2:0]   start_wid = '0;
   logic [31:0]  start_pc = '0;
   logic [7:0]   ib_req = '0, stall = '0, redir_valid = '0, exit_valid = '0;
   logic [255:0] redir_pc_flat = '0;
   logic [1:0]   fetch_valid;
   logic [5:0]   fetch_wid_flat;
   logic [63:0]  fetch_pc_flat;
   logic [7:0]   kill, active;
   logic         all_done;

   // 16-warp / 4-lane instance
   logic          s16_valid = 1'b0;
   logic [3:0]    s16_wid = '0;
   logic [31:0]   s16_pc = '0;
   logic [15:0]   ib16 = '0;
   logic [15:0]   fv16, kill16, act16;
   logic [15:0]   wid16;
   logic [127:0]  pc16;
   logic          done16;

`ifdef WFA_PERF_CNT_EN
   logic [31:0] pg8, ps8, pg16, ps16;
`endif

   warp_fetch_arbiter dut8 (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_wid(start_wid),
      .start_pc(start_pc), .ib_req(ib_req), .stall(stall), .redir_valid(redir_valid),
      .redir_pc_flat(redir_pc_flat), .exit_valid(exit_valid), .fetch_valid(fetch_valid),
      .fetch_wid_flat(fetch_wid_flat), .fetch_pc_flat(fetch_pc_flat), .kill(kill),
      .active(active), .all_done(all_done)
`ifdef WFA_PERF_CNT_EN
     ,.perf_grants(pg8), .perf_starve(ps8)
`endif
   );

   warp_fetch_arbiter #(.NUM_WARPS(16), .FETCH_WIDTH(4), .ADDR_W(32), .WID_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start_valid(s16_valid), .start_wid(s16_wid),
      .start_pc(s16_pc), .ib_req(ib16), .stall(16'h0), .redir_valid(16'h0),
      .redir_pc_flat(512'h0), .exit_valid(16'h0), .fetch_valid(fv16[3:0]),
      .fetch_wid_flat(wid16), .fetch_pc_flat(pc16), .kill(kill16),
      .active(act16), .all_done(done16)
`ifdef WFA_PERF_CNT_EN
     ,.perf_grants(pg16), .perf_starve(ps16)
`endif
   );
   assign fv16[15:4] = '0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        sv;  logic [2:0] sw;  logic [31:0] spc;
      logic [7:0]  ib;  logic [7:0] st;
      logic        rv;  logic [2:0] rw;  logic [31:0] rpc;
      logic [7:0]  ex;
      logic [1:0]  fv;  logic [2:0] w0;  logic [31:0] p0;
      logic [2:0]  w1;  logic [31:0] p1;
      logic [7:0]  kl;  logic [7:0] act; logic dn;
   } vec_t;

   function automatic vec_t v(logic sv, logic [2:0] sw, logic [31:0] spc, logic [7:0] ib,
                              logic [7:0] st, logic rv, logic [2:0] rw, logic [31:0] rpc,
                              logic [7:0] ex, logic [1:0] fv, logic [2:0] w0, logic [31:0] p0,
                              logic [2:0] w1, logic [31:0] p1, logic [7:0] kl,
                              logic [7:0] act, logic dn);
      vec_t t;
      t.sv = sv; t.sw = sw; t.spc = spc; t.ib = ib; t.st = st; t.rv = rv; t.rw = rw;
      t.rpc = rpc; t.ex = ex; t.fv = fv; t.w0 = w0; t.p0 = p0; t.w1 = w1; t.p1 = p1;
      t.kl = kl; t.act = act; t.dn = dn;
      return t;
   endfunction

   task automatic check8(input string tag, input logic [1:0] fv, input logic [2:0] w0,
                         input logic [31:0] p0, input logic [2:0] w1, input logic [31:0] p1,
                         input logic [7:0] kl, input logic [7:0] act, input logic dn);
      chk({tag, ".fv"},   32'(fetch_valid), 32'(fv));
      chk({tag, ".wid0"}, 32'(fetch_wid_flat[2:0]), 32'(w0));
      chk({tag, ".pc0"},  fetch_pc_flat[31:0], p0);
      chk({tag, ".wid1"}, 32'(fetch_wid_flat[5:3]), 32'(w1));
      chk({tag, ".pc1"},  fetch_pc_flat[63:32], p1);
      chk({tag, ".kill"}, 32'(kill), 32'(kl));
      chk({tag, ".active"}, 32'(active), 32'(act));
      chk({tag, ".done"}, 32'(all_done), 32'(dn));
   endtask

   task automatic apply(input vec_t t, input int idx);
      start_valid = t.sv; start_wid = t.sw; start_pc = t.spc;
      ib_req = t.ib; stall = t.st; exit_valid = t.ex;
      redir_valid = t.rv ? (8'b1 << t.rw) : 8'h0;
      for (int w = 0; w < 8; w++)
         redir_pc_flat[w*32 +: 32] = (t.rv && w == int'(t.rw)) ? t.rpc : (32'hDEAD0000 | 32'(w));
      @(posedge clk); #1;
      check8($sformatf("v%0d", idx), t.fv, t.w0, t.p0, t.w1, t.p1, t.kl, t.act, t.dn);
   endtask

   task automatic idle8();
      start_valid = 1'b0; ib_req = '0; stall = '0; redir_valid = '0; exit_valid = '0;
   endtask

   function automatic logic [31:0] base16(int w);
      return (w == 15) ? 32'hFFFF_FFFC : 32'(w * 16);
   endfunction

   vec_t tv[$];

   initial begin
      // Launch all eight with ib_req low so the first grant sees the full population.
      for (int i = 0; i < 8; i++)
         tv.push_back(v(1, 3'(i), 32'(i * 256), 8'h00, 8'h00, 0, 0, 0, 8'h00,
                        2'b00, 0, 0, 0, 0, 8'h00, 8'((1 << (i + 1)) - 1), 0));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 0,0,0, 8'h00, 2'b11, 0,32'h000, 1,32'h100, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 0,0,0, 8'h00, 2'b11, 2,32'h200, 3,32'h300, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 0,0,0, 8'h00, 2'b11, 4,32'h400, 5,32'h500, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 0,0,0, 8'h00, 2'b11, 6,32'h600, 7,32'h700, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 0,0,0, 8'h00, 2'b11, 0,32'h004, 1,32'h104, 8'h00,8'hFF,0));
      // Only warps 0 and 3 requesting; warp 3 stalled for three cycles.
      tv.push_back(v(0,0,0, 8'h09,8'h08, 0,0,0, 8'h00, 2'b01, 0,32'h008, 0,32'h0, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'h09,8'h08, 0,0,0, 8'h00, 2'b01, 0,32'h00C, 0,32'h0, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'h09,8'h08, 0,0,0, 8'h00, 2'b01, 0,32'h010, 0,32'h0, 8'h00,8'hFF,0));
      tv.push_back(v(0,0,0, 8'h09,8'h00, 0,0,0, 8'h00, 2'b11, 3,32'h304, 0,32'h014, 8'h00,8'hFF,0));
      // Redirect warp 2 in the cycle it would be granted.
      tv.push_back(v(0,0,0, 8'h04,8'h00, 1,2,32'h800, 8'h00, 2'b00, 0,0, 0,0, 8'h04,8'hFF,0));
      tv.push_back(v(0,0,0, 8'h04,8'h00, 0,0,0, 8'h00, 2'b01, 2,32'h800, 0,0, 8'h00,8'hFF,0));
      // Start beats exit on running warp 5.
      tv.push_back(v(1,5,32'h200, 8'h00,8'h00, 0,0,0, 8'h20, 2'b00, 0,0, 0,0, 8'h20,8'hFF,0));
      tv.push_back(v(0,0,0, 8'h20,8'h00, 0,0,0, 8'h00, 2'b01, 5,32'h200, 0,0, 8'h00,8'hFF,0));
      // Everything exits; then redirect/exit on idle warps must be ignored.
      tv.push_back(v(0,0,0, 8'h00,8'h00, 0,0,0, 8'hFF, 2'b00, 0,0, 0,0, 8'hFF,8'h00,1));
      tv.push_back(v(0,0,0, 8'h00,8'h00, 0,0,0, 8'h00, 2'b00, 0,0, 0,0, 8'h00,8'h00,1));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 1,3,32'h999, 8'h08, 2'b00, 0,0, 0,0, 8'h00,8'h00,1));
      tv.push_back(v(1,4,32'h40, 8'h00,8'h00, 0,0,0, 8'h00, 2'b00, 0,0, 0,0, 8'h00,8'h10,0));
      tv.push_back(v(0,0,0, 8'hFF,8'h00, 0,0,0, 8'h00, 2'b01, 4,32'h040, 0,0, 8'h00,8'h10,0));

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check8("reset", 2'b00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
      chk("reset.act16", 32'(act16), 32'h0);
      rst_n = 1'b1;

      foreach (tv[i]) apply(tv[i], i);

      // Mid-stream reset: a launch plus a live grant, then one reset edge.
      idle8();
      start_valid = 1'b1; start_wid = 3'd6; start_pc = 32'h900; ib_req = 8'hFF;
      @(posedge clk); #1;
      check8("pre_rst", 2'b01, 4, 32'h044, 0, 0, 8'h00, 8'h50, 0);
      start_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      check8("mid_rst", 2'b00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check8("post_rst", 2'b00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
      // Pointer must be back at 0: warp 1 outranks warp 7.
      idle8();
      start_valid = 1'b1; start_wid = 3'd7; start_pc = 32'h70;
      @(posedge clk); #1;
      start_wid = 3'd1; start_pc = 32'h10;
      @(posedge clk); #1;
      start_valid = 1'b0; ib_req = 8'hFF;
      @(posedge clk); #1;
      check8("ptr_rst", 2'b11, 1, 32'h10, 7, 32'h70, 8'h00, 8'h82, 0);
      idle8();

      // 16 warps, 4 lanes; warp 15 sits at the top of the address space.
      for (int w = 0; w < 16; w++) begin
         s16_valid = 1'b1; s16_wid = 4'(w); s16_pc = base16(w);
         @(posedge clk); #1;
      end
      s16_valid = 1'b0; ib16 = 16'hFFFF;
      chk("w16.active", 32'(act16), 32'hFFFF);
      begin
`ifdef WFA_PERF_CNT_EN
         logic [31:0] pg_prev, ps_prev;
         pg_prev = pg16; ps_prev = ps16;
`endif
         for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("w16.c%0d.fv", k), 32'(fv16), 32'hF);
            for (int l = 0; l < 4; l++) begin
               int w;
               w = 4 * (k % 4) + l;
               chk($sformatf("w16.c%0d.l%0d.wid", k, l), 32'(wid16[l*4 +: 4]), 32'(w));
               chk($sformatf("w16.c%0d.l%0d.pc", k, l), pc16[l*32 +: 32],
                   base16(w) + 32'(4 * (k / 4)));
            end
`ifdef WFA_PERF_CNT_EN
            if (k > 0) chk($sformatf("w16.c%0d.perf_grants", k), pg16 - pg_prev, 32'd4);
            chk($sformatf("w16.c%0d.perf_starve", k), ps16, ps_prev);
            pg_prev = pg16;
`endif
         end
      end
      chk("w16.wrap_pc", pc16[127:96], 32'h0000_0000);
      ib16 = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/warp_fetch_arbiter.md
Name: warp_fetch_arbiter

Overview:
Parametrised per-warp PC table and multi-grant fetch scheduler for the SM front end, generalising the fixed 8-warp/2-grant PC stage. Holds one PC and a lifecycle state per warp. Each cycle it picks up to FETCH_WIDTH eligible warps in rotating-priority order and presents their PCs to the I-cache one cycle later. It handles launch, branch/SIMT redirect and exit, and emits per-warp kill pulses so downstream stages can drop in-flight work.

Parameters:
NUM_WARPS, 8, number of warps (power of two, 2..32)
FETCH_WIDTH, 2, maximum grants per cycle (1..NUM_WARPS)
ADDR_W, 32, PC width
WID_W, 3, warp-ID width; must equal log2(NUM_WARPS)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous and active-low
start_valid  in  1  thread manager launches warp start_wid
start_wid  in  WID_W  warp being launched
start_pc  in  ADDR_W  launch PC
ib_req  in  NUM_WARPS  I-buffer has space for warp w
stall  in  NUM_WARPS  SIMT stall for warp w
redir_valid  in  NUM_WARPS  redirect warp w (ALU/SIMT/decode, pre-merged)
redir_pc_flat  in  NUM_WARPS*ADDR_W  redirect targets; warp w at bits [w*ADDR_W +: ADDR_W]
exit_valid  in  NUM_WARPS  decode saw EXIT for warp w
fetch_valid  out  FETCH_WIDTH  lane l carries a fetch
fetch_wid_flat  out  FETCH_WIDTH*WID_W  warp ID per lane
fetch_pc_flat  out  FETCH_WIDTH*ADDR_W  PC per lane
kill  out  NUM_WARPS  squash in-flight fetches of warp w
active  out  NUM_WARPS  warp state is RUN
all_done  out  1  every warp IDLE, with at least one exit seen since reset

Behaviour:
- Reset, evaluated at posedge clk while rst_n=0:
  - all PCs 0; all warps IDLE; rotation pointer 0
  - fetch_valid/wid/pc 0; kill 0; all_done 0
- Per-warp state:
  - IDLE -> RUN on start (start_valid and start_wid==w)
  - RUN -> IDLE on exit_valid[w]
  - start on a RUN warp restarts it: PC reloaded, stays RUN
- eligible[w] = RUN & ib_req[w] & ~stall[w] & ~redir_valid[w] & ~exit_valid[w] & ~(start hitting w).
- Grant:
  - Scan warps circularly from the pointer; grant the first min(FETCH_WIDTH, #eligible).
  - Lane 0 takes the highest-priority grant, lane 1 the next, and so on.
  - Pointer moves to (last granted warp + 1) mod NUM_WARPS; unchanged if nothing is granted.
- PC update priority per warp, same edge: start > exit (PC holds) > redirect (PC <= target) > grant (PC <= PC+4, modulo 2^ADDR_W wrap).
- Redirect or exit on an IDLE warp is ignored.
- Latency:
  - The grant decision in cycle N is registered; fetch_* is valid in cycle N+1 and carries the PC before the +4.
  - Unused lanes drive valid 0, wid 0, pc 0.
- kill[w] is registered: it pulses in cycle N+1 when, in cycle N, a RUN warp w saw redir_valid, exit_valid or a restart start.
  - Downstream discards warp w entries fetched in cycles <= N+1.
  - fetch_valid is never asserted for w in the same cycle as kill[w].
- all_done is registered: set once all warps are IDLE after at least one exit; cleared by any start.
- Mid-operation reset clears all state at the next edge; no pending fetch survives.

Optional Feature:
Macro WFA_PERF_CNT_EN.
- Defined: adds outputs perf_grants (32) and perf_starve (32).
  - perf_grants accumulates the popcount of fetch_valid each cycle.
  - perf_starve increments on cycles where any warp is RUN but no grant is made.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Default parameters; start warps 0..7 with PC=0x100*w, all ib_req=1, stall=0 -> cycle after the last start: lanes {0,1}, PCs 0x000/0x100; next cycles {2,3},{4,5},{6,7},{0,1}; warp 0 second fetch PC 0x004.
2. Warps 0,3 RUN; stall[3]=1 for 3 cycles -> only warp 0 fetched (lane 1 valid 0); warp 3 resumes at its unchanged PC after stall drops.
3. Warp 2 RUN at PC 0x40; redir_valid[2] with target 0x800 in the same cycle it would be granted -> no grant; kill[2] pulses the next cycle; next fetch of warp 2 has PC 0x800.
4. Simultaneous start_wid=5 (PC 0x200) and exit_valid[5] on RUN warp 5 -> start wins: warp 5 stays RUN with PC 0x200, kill[5] pulses once.
5. All RUN warps exit -> all_done=1 the cycle after; a new start clears it; rst_n=0 for one edge mid-stream -> all outputs 0 the next cycle.
6. NUM_WARPS=16, FETCH_WIDTH=4, PC=0xFFFFFFFC on warp 15 -> 4 lanes granted per cycle; warp 15 next PC wraps to 0x00000000; with WFA_PERF_CNT_EN, perf_grants increments by 4 per cycle.
